uart_tx_scheduler: RTL and testbench

//  Shares one uart transmitter among NREQ byte requesters with round-robin arbitration.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_scheduler_rr_pick.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart transmit scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_t;

    localparam int CTRL_W            = 5;
    localparam int WAIT_BUSY_TIMEOUT = 4;
    localparam int TMO_W             = 3;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NREQ. Produces a one-hot grant, its index and a hit flag.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam int PW = IDX_W + 1;

    logic [PW-1:0] pos_s;

    // Scan requests starting at ptr and keep the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos_s = {1'b0, ptr} + PW'(i);
            if (pos_s >= PW'(NREQ)) begin
                pos_s = pos_s - PW'(NREQ);
            end else begin
                pos_s = pos_s;
            end
            if (!any && req[pos_s[IDX_W-1:0]]) begin
                onehot[pos_s[IDX_W-1:0]] = 1'b1;
                idx                      = pos_s[IDX_W-1:0];
                any                      = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart transmitter among NREQ byte requesters (round robin),
// sequences tx_start against tx_busy, generates baud16_en and only
// applies a new ctrl_word between frames.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DIV_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic [CTRL_W-1:0]       cfg_ctrl,
    input  logic [DIV_W-1:0]        baud_div,
    output logic [CTRL_W-1:0]       ctrl_word,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    output logic                    baud16_en,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    sched_busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_BUSY_TIMEOUT - 1);

    sched_state_t      state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              baud_en_q, baud_en_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              sched_busy_q, sched_busy_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic [NREQ-1:0]   pick_onehot_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic [7:0]        pick_byte_s;
    logic              grant_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign grant_s = (state_q == IDLE) && !tx_busy && pick_any_s;

    // Select the winner's byte with an AND-OR mux over the one-hot grant.
    always_comb begin
        pick_byte_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            pick_byte_s = pick_byte_s | (req_data[8*i +: 8] & {8{pick_onehot_s[i]}});
        end
    end

    // Free-running baud16 divider; the divisor is latched at each wrap so a
    // change never truncates or stretches the period in progress.
    always_comb begin
        if (cnt_q == div_q) begin
            baud_en_d = 1'b1;
            cnt_d     = '0;
            div_d     = baud_div;
        end else begin
            baud_en_d = 1'b0;
            cnt_d     = cnt_q + DIV_W'(1);
            div_d     = div_q;
        end
    end

    // Baud divider registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_q     <= baud_div;
            baud_en_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            baud_en_q <= baud_en_d;
        end
    end

    // Scheduler next-state logic.
    always_comb begin
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler output and datapath next values.
    always_comb begin
        req_ready_d  = '0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        ptr_d        = ptr_q;
        ctrl_d       = ctrl_q;
        tmo_d        = '0;
        sched_busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                ctrl_d = cfg_ctrl;
                if (grant_s) begin
                    req_ready_d = pick_onehot_s;
                    tx_data_d   = pick_byte_s;
                    grant_id_d  = pick_idx_s;
                    if (pick_idx_s == IDX_W'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = pick_idx_s + IDX_W'(1);
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ISSUE: begin
                tx_start_d = 1'b1;
            end
            WAIT_BUSY: begin
                tmo_d = tmo_q + TMO_W'(1);
            end
            WAIT_DONE: begin
                tmo_d = '0;
            end
            default: begin
                tmo_d = '0;
            end
        endcase
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, round-robin pointer and busy timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready_q  <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            grant_id_q   <= '0;
            ptr_q        <= '0;
            ctrl_q       <= cfg_ctrl;
            tmo_q        <= '0;
            sched_busy_q <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            ptr_q        <= ptr_d;
            ctrl_q       <= ctrl_d;
            tmo_q        <= tmo_d;
            sched_busy_q <= sched_busy_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign grant_id   = grant_id_q;
    assign ctrl_word  = ctrl_q;
    assign baud16_en  = baud_en_q;
    assign sched_busy = sched_busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: randomized requesters, a simple
// uart busy model and a monitor checking against a transaction-level model.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int DIV_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4:0]        cfg_ctrl = 5'b01011;
    logic [DIV_W-1:0]  baud_div = 12'd3;
    logic [4:0]        ctrl_word;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              baud16_en;
    logic              tx_busy = 1'b0;
    logic [1:0]        grant_id;
    logic              sched_busy;

    uart_tx_scheduler #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .cfg_ctrl   (cfg_ctrl),
        .baud_div   (baud_div),
        .ctrl_word  (ctrl_word),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .baud16_en  (baud16_en),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // scoreboard: pending byte per requester, expected frame lengths
    logic [7:0] exp_q [NREQ][$];
    int         len_q [$];
    int         ptr_m = 0;

    // uart model controls
    bit uart_dead = 1'b0;
    int len_min   = 1;
    int len_max   = 8;
    int busy_cnt  = 0;

    // monitor state
    int         m_last_pulse = 0;
    int         m_exp_len    = 1;
    int         m_start_due  = -1;
    int         m_hi_cnt     = 0;
    int         m_w          = 0;
    bit         m_in_frame   = 1'b0;
    logic       m_prev_sb    = 1'b0;
    logic [4:0] m_prev_ctrl  = 5'd0;
    logic [4:0] m_exp_ctrl   = 5'd0;
    logic [7:0] m_last_data  = 8'h00;
    int         m_last_gid   = 0;
    logic [7:0] m_eb         = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Round-robin winner: first valid index at or after p, modulo NREQ.
    function automatic int rr_win(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Uart model: on tx_start goes busy for L cycles (or never, when dead).
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (uart_dead) begin
                    len_q.push_back(5);
                end else begin
                    busy_cnt = $urandom_range(len_max, len_min);
                    len_q.push_back(2 + busy_cnt);
                end
            end
            if (busy_cnt > 0) begin
                tx_busy  = 1'b1;
                busy_cnt = busy_cnt - 1;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                check("rst_req_ready", 32'(req_ready), 32'd0);
                check("rst_tx_start", 32'(tx_start), 32'd0);
                check("rst_tx_data", 32'(tx_data), 32'd0);
                check("rst_grant_id", 32'(grant_id), 32'd0);
                check("rst_sched_busy", 32'(sched_busy), 32'd0);
                check("rst_baud16_en", 32'(baud16_en), 32'd0);
                check("rst_ctrl_word", 32'(ctrl_word), 32'(cfg_ctrl));
                ptr_m = 0;
                len_q.delete();
                m_in_frame   = 1'b0;
                m_start_due  = -1;
                m_prev_sb    = 1'b0;
                m_prev_ctrl  = cfg_ctrl;
                m_last_data  = 8'h00;
                m_last_gid   = 0;
                m_last_pulse = cyc;
                m_exp_len    = int'(baud_div) + 1;
            end else begin
                // baud tick period
                if (baud16_en) begin
                    check("baud_period", 32'(cyc - m_last_pulse), 32'(m_exp_len));
                    m_last_pulse = cyc;
                    m_exp_len    = int'(baud_div) + 1;
                end else if (cyc - m_last_pulse >= m_exp_len) begin
                    check("baud_missing", 32'(baud16_en), 32'd1);
                    m_last_pulse = cyc;
                    m_exp_len    = int'(baud_div) + 1;
                end
                // ctrl_word follows cfg_ctrl only while idle
                m_exp_ctrl = m_prev_sb ? m_prev_ctrl : cfg_ctrl;
                check("ctrl_word", 32'(ctrl_word), 32'(m_exp_ctrl));
                m_prev_ctrl = m_exp_ctrl;
                // grant decision
                if (!m_prev_sb && !tx_busy && (|req_valid)) begin
                    m_w = rr_win(req_valid, ptr_m);
                    check("req_ready", 32'(req_ready), 32'(1 << m_w));
                    check("grant_id", 32'(grant_id), 32'(m_w));
                    if (exp_q[m_w].size() > 0) begin
                        m_eb = exp_q[m_w].pop_front();
                    end else begin
                        m_eb = 8'h00;
                    end
                    check("tx_data_grant", 32'(tx_data), 32'(m_eb));
                    ptr_m        = (m_w + 1) % NREQ;
                    m_start_due  = cyc + 1;
                    m_in_frame   = 1'b1;
                    m_hi_cnt     = 0;
                    m_last_data  = m_eb;
                    m_last_gid   = m_w;
                end else begin
                    check("no_req_ready", 32'(req_ready), 32'd0);
                    check("tx_data_hold", 32'(tx_data), 32'(m_last_data));
                    check("grant_id_hold", 32'(grant_id), 32'(m_last_gid));
                end
                check("tx_start", 32'(tx_start), 32'(cyc == m_start_due));
                // frame length and busy indication
                if (m_in_frame) begin
                    if (sched_busy) begin
                        m_hi_cnt++;
                    end else begin
                        if (len_q.size() > 0) begin
                            check("frame_len", 32'(m_hi_cnt), 32'(len_q.pop_front()));
                        end else begin
                            check("frame_len", 32'(m_hi_cnt), 32'hFFFF_FFFF);
                        end
                        m_in_frame = 1'b0;
                    end
                end
                check("sched_busy", 32'(sched_busy), 32'(m_in_frame));
                m_prev_sb = sched_busy;
            end
        end
    end

    // One requester cycle: handshake, optional abandon, optional new byte.
    task automatic drive_cycle(input logic [NREQ-1:0] mask, input int prob, input bit abandon_en);
        logic [7:0] b;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] === 1'b1) begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end else if (req_valid[i] && abandon_en && $urandom_range(15, 0) == 0) begin
                req_valid[i] = 1'b0;
                b = exp_q[i].pop_back();
            end
            if (!req_valid[i] && mask[i] && int'($urandom_range(99, 0)) < prob) begin
                b = 8'($urandom);
                req_data[8*i +: 8] = b;
                req_valid[i]       = 1'b1;
                exp_q[i].push_back(b);
            end
        end
    endtask

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // idle with baud_div=3
        repeat (20) drive_cycle(4'b0000, 0, 1'b0);

        // single request A5, ctrl change mid-frame
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        exp_q[0].push_back(8'hA5);
        repeat (3) drive_cycle(4'b0000, 0, 1'b0);
        cfg_ctrl = 5'b00111;
        repeat (25) drive_cycle(4'b0000, 0, 1'b0);

        // all requesters continuously valid
        @(negedge clk);
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        for (int i = 0; i < NREQ; i++) exp_q[i].push_back(req_data[8*i +: 8]);
        repeat (80) drive_cycle(4'b1111, 100, 1'b0);
        repeat (30) drive_cycle(4'b0000, 0, 1'b0);

        // single requester back-to-back
        repeat (40) drive_cycle(4'b0001, 100, 1'b0);
        repeat (20) drive_cycle(4'b0000, 0, 1'b0);

        // random traffic, config and divisor changes, abandons
        for (int c = 0; c < 600; c++) begin
            drive_cycle(4'($urandom), 30, 1'b1);
            if ($urandom_range(19, 0) == 0) cfg_ctrl = 5'($urandom);
            if ($urandom_range(49, 0) == 0) baud_div = 12'($urandom_range(5, 0));
        end

        // unresponsive uart: busy timeout
        uart_dead = 1'b1;
        repeat (120) drive_cycle(4'($urandom), 40, 1'b1);
        uart_dead = 1'b0;
        repeat (10) drive_cycle(4'b0000, 0, 1'b0);

        // reset while waiting for the frame to finish
        len_min = 15;
        len_max = 15;
        guard   = 0;
        while (!(tx_busy === 1'b1 && sched_busy === 1'b1) && guard < 300) begin
            drive_cycle(4'b1111, 50, 1'b0);
            guard++;
        end
        check("reach_wait_done", 32'({tx_busy, sched_busy}), 32'd3);
        repeat (2) drive_cycle(4'b0000, 0, 1'b0);
        rst_n = 1'b0;
        drive_cycle(4'b1111, 100, 1'b0);
        rst_n   = 1'b1;
        len_min = 1;
        len_max = 8;
        repeat (60) drive_cycle(4'($urandom), 30, 1'b0);

        // drain outstanding requests
        repeat (80) drive_cycle(4'b0000, 0, 1'b0);
        check("all_drained", 32'(req_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
